// File: rtl/quad_decoder.sv
// Quadrature encoder receiver: synchronizes and glitch-filters the A/B phases,
// decodes single steps into a wrapping position count and a per-window velocity.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_INIT | after reset; first change only loads the reference phase
// ST_RUN  | normal decoding of CW / CCW steps and illegal transitions
module quad_decoder #(
   parameter int PWIDTH   = 16,
   parameter int VWIDTH   = 12,
   parameter int FILT_CYC = 3,
   parameter int WIN_CYC  = 1000
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              iA,
   input  logic              iB,
   input  logic              ZERO,
   input  logic              ERR_CLR,
   output logic [PWIDTH-1:0] POS,
   output logic              DIR,
   output logic              STEP,
   output logic              ERR,
   output logic [VWIDTH-1:0] VEL,
   output logic              VEL_VALID
);

   localparam int FW = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
   localparam int IW = $clog2(FILT_CYC + 3);
   localparam int WW = $clog2(WIN_CYC);

   localparam logic [FW-1:0]     FILT_M1 = FW'(FILT_CYC - 1);
   localparam logic [IW-1:0]     INIT_M1 = IW'(FILT_CYC + 1);
   localparam logic [WW-1:0]     WIN_M1  = WW'(WIN_CYC - 1);
   localparam logic [VWIDTH-1:0] VMAX    = {1'b0, {(VWIDTH-1){1'b1}}};
   localparam logic [VWIDTH-1:0] VMIN    = {1'b1, {(VWIDTH-1){1'b0}}};

   typedef enum logic {ST_INIT, ST_RUN} dec_state_t;

   dec_state_t        state, state_nxt;
   logic [1:0]        sync1, sync2, filt, ab_prev, chg;
   logic [FW-1:0]     fcnt [2];
   logic [IW-1:0]     icnt, icnt_nxt;
   logic [WW-1:0]     wcnt;
   logic [VWIDTH-1:0] acc, acc_nxt;
   logic              step_cw, step_ccw, illegal;

   // gray phase {A,B} to ordinal: 00->0, 10->1, 11->2, 01->3
   function automatic logic [1:0] phase_idx(input logic [1:0] ab);
      return {ab[0], ab[1] ^ ab[0]};
   endfunction

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= {iA, iB};
         sync2 <= sync1;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         filt    <= '0;
         fcnt[0] <= '0;
         fcnt[1] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == filt[i]) begin
               fcnt[i] <= '0;
            end else if (fcnt[i] == FILT_M1) begin
               filt[i] <= sync2[i];
               fcnt[i] <= '0;
            end else begin
               fcnt[i] <= fcnt[i] + 1'b1;
            end
         end
      end
   end

   assign chg = filt ^ ab_prev;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state   <= ST_INIT;
         icnt    <= '0;
         ab_prev <= '0;
      end else begin
         state   <= state_nxt;
         icnt    <= icnt_nxt;
         ab_prev <= filt;
      end
   end

   always_comb begin
      state_nxt = state;
      icnt_nxt  = icnt;
      step_cw   = 1'b0;
      step_ccw  = 1'b0;
      illegal   = 1'b0;
      case (state)
         ST_INIT: begin
            if (chg != 2'b00 || icnt == INIT_M1) begin
               state_nxt = ST_RUN;
            end else begin
               icnt_nxt = icnt + 1'b1;
            end
         end
         ST_RUN: begin
            if (chg == 2'b11) begin
               illegal = 1'b1;
            end else if (chg != 2'b00) begin
               if (phase_idx(ab_prev) + 2'd1 == phase_idx(filt)) begin
                  step_cw = 1'b1;
               end else begin
                  step_ccw = 1'b1;
               end
            end
         end
         default: state_nxt = ST_INIT;
      endcase
   end

   // ZERO only overrides the position; STEP/DIR/velocity still see the step
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         POS  <= '0;
         DIR  <= 1'b0;
         STEP <= 1'b0;
         ERR  <= 1'b0;
      end else begin
         STEP <= step_cw | step_ccw;
         if (step_cw) begin
            DIR <= 1'b1;
         end else if (step_ccw) begin
            DIR <= 1'b0;
         end
         if (ZERO) begin
            POS <= '0;
         end else if (step_cw) begin
            POS <= POS + 1'b1;
         end else if (step_ccw) begin
            POS <= POS - 1'b1;
         end
         if (illegal) begin
            ERR <= 1'b1;
         end else if (ERR_CLR) begin
            ERR <= 1'b0;
         end
      end
   end

   always_comb begin
      acc_nxt = acc;
      if (step_cw && acc != VMAX) begin
         acc_nxt = acc + 1'b1;
      end else if (step_ccw && acc != VMIN) begin
         acc_nxt = acc - 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wcnt      <= '0;
         acc       <= '0;
         VEL       <= '0;
         VEL_VALID <= 1'b0;
      end else begin
         VEL_VALID <= 1'b0;
         if (wcnt == WIN_M1) begin
            wcnt      <= '0;
            acc       <= '0;
            VEL       <= acc_nxt;
            VEL_VALID <= 1'b1;
         end else begin
            wcnt <= wcnt + 1'b1;
            acc  <= acc_nxt;
         end
      end
   end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: a spec-default instance plus a FILT_CYC=1
// instance that can step every cycle to reach the position wrap points.
module tb_quad_decoder;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b1;
   logic        iA = 1'b0, iB = 1'b0, ZERO = 1'b0, ERR_CLR = 1'b0;
   logic [15:0] POS;
   logic        DIR, STEP, ERR, VEL_VALID;
   logic [11:0] VEL;

   logic        fa = 1'b0, fb = 1'b0, fzero = 1'b0, fclr = 1'b0;
   logic [15:0] f_pos;
   logic        f_dir, f_step, f_err, f_vv;
   logic [11:0] f_vel;

   int n_pass = 0, n_total = 0;
   int step_cnt = 0, cyc = 0;
   int midx = 0, fidx = 0;

   quad_decoder #(.PWIDTH(16), .VWIDTH(12), .FILT_CYC(3), .WIN_CYC(1000)) dut (
      .CLK(CLK), .RST_N(RST_N), .iA(iA), .iB(iB), .ZERO(ZERO), .ERR_CLR(ERR_CLR),
      .POS(POS), .DIR(DIR), .STEP(STEP), .ERR(ERR), .VEL(VEL), .VEL_VALID(VEL_VALID));

   quad_decoder #(.PWIDTH(16), .VWIDTH(12), .FILT_CYC(1), .WIN_CYC(4000)) dut_fast (
      .CLK(CLK), .RST_N(RST_N), .iA(fa), .iB(fb), .ZERO(fzero), .ERR_CLR(fclr),
      .POS(f_pos), .DIR(f_dir), .STEP(f_step), .ERR(f_err), .VEL(f_vel), .VEL_VALID(f_vv));

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;
   always @(posedge CLK) if (STEP === 1'b1) step_cnt <= step_cnt + 1;

   function automatic logic [1:0] gray(input int i);
      case (i)
         0: return 2'b00;
         1: return 2'b10;
         2: return 2'b11;
         default: return 2'b01;
      endcase
   endfunction

   // one encoder step on the main instance; called and returns on a negedge
   task automatic main_step(input bit cw, input int gap, input bit zero_hit, output int lat);
      midx = cw ? (midx + 1) % 4 : (midx + 3) % 4;
      {iA, iB} = gray(midx);
      lat = -1;
      for (int k = 1; k <= gap; k++) begin
         @(negedge CLK);
         if (STEP === 1'b1 && lat < 0) lat = k;
         if (k == 5) ZERO = zero_hit;
         if (k == 6) ZERO = 1'b0;
      end
   endtask

   task automatic fast_steps(input bit cw, input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge CLK);
         fidx = cw ? (fidx + 1) % 4 : (fidx + 3) % 4;
         {fa, fb} = gray(fidx);
      end
      repeat (8) @(negedge CLK);
   endtask

   task automatic wait_vel_valid(output int t, output bit ok);
      ok = 1'b0;
      t = 0;
      for (int k = 0; k < 1200; k++) begin
         @(negedge CLK);
         if (VEL_VALID === 1'b1) begin
            ok = 1'b1;
            t = cyc;
            break;
         end
      end
   endtask

   task automatic test_reset();
      #2 RST_N = 1'b0;
      #1;
      n_total++;
      if ({POS, DIR, STEP, ERR, VEL, VEL_VALID} !== 32'd0)
         $display("FAIL reset_outputs: got %h want 0", {POS, DIR, STEP, ERR, VEL, VEL_VALID});
      else n_pass++;
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;
      repeat (10) @(negedge CLK);
   endtask

   task automatic test_cw_steps();
      int lat;
      int s0;
      s0 = step_cnt;
      for (int i = 0; i < 8; i++) begin
         main_step(1'b1, 400, 1'b0, lat);
         n_total++;
         if (lat !== 6) $display("FAIL cw_latency[%0d]: got %0d want 6", i, lat);
         else n_pass++;
      end
      n_total++;
      if (POS !== 16'd8) $display("FAIL cw_pos: got %0d want 8", POS); else n_pass++;
      n_total++;
      if (DIR !== 1'b1) $display("FAIL cw_dir: got %b want 1", DIR); else n_pass++;
      n_total++;
      if (step_cnt - s0 !== 8) $display("FAIL cw_step_count: got %0d want 8", step_cnt - s0);
      else n_pass++;
      n_total++;
      if (ERR !== 1'b0) $display("FAIL cw_err: got %b want 0", ERR); else n_pass++;
   endtask

   task automatic test_ccw_zero();
      int lat;
      for (int i = 0; i < 3; i++) main_step(1'b0, 100, 1'b0, lat);
      n_total++;
      if (POS !== 16'd5) $display("FAIL ccw_pos: got %0d want 5", POS); else n_pass++;
      n_total++;
      if (DIR !== 1'b0) $display("FAIL ccw_dir: got %b want 0", DIR); else n_pass++;
      main_step(1'b1, 100, 1'b1, lat);
      n_total++;
      if (POS !== 16'd0) $display("FAIL zero_with_step_pos: got %0d want 0", POS); else n_pass++;
      n_total++;
      if ({lat == 6, DIR} !== 2'b11)
         $display("FAIL zero_with_step_stepdir: got lat=%0d dir=%b want lat=6 dir=1", lat, DIR);
      else n_pass++;
   endtask

   task automatic test_glitch();
      logic [15:0] p;
      int s;
      p = POS;
      s = step_cnt;
      iA = ~iA;
      repeat (2) @(negedge CLK);
      iA = ~iA;
      repeat (20) @(negedge CLK);
      n_total++;
      if ({step_cnt - s, POS} !== {32'd0, p})
         $display("FAIL glitch2_ignored: got steps=%0d pos=%0d want steps=0 pos=%0d", step_cnt - s, POS, p);
      else n_pass++;
      iA = ~iA;
      repeat (3) @(negedge CLK);
      iA = ~iA;
      repeat (30) @(negedge CLK);
      n_total++;
      if ({step_cnt - s, POS, ERR} !== {32'd2, p, 1'b0})
         $display("FAIL pulse3_counted: got steps=%0d pos=%0d err=%b want steps=2 pos=%0d err=0",
                  step_cnt - s, POS, ERR, p);
      else n_pass++;
   endtask

   task automatic test_illegal();
      logic [15:0] p;
      int s;
      p = POS;
      s = step_cnt;
      {iA, iB} = {iA, iB} ^ 2'b11;
      midx = (midx + 2) % 4;
      repeat (20) @(negedge CLK);
      n_total++;
      if ({ERR, POS, step_cnt - s} !== {1'b1, p, 32'd0})
         $display("FAIL illegal_err: got err=%b pos=%0d steps=%0d want err=1 pos=%0d steps=0",
                  ERR, POS, step_cnt - s, p);
      else n_pass++;
      ERR_CLR = 1'b1;
      @(negedge CLK);
      ERR_CLR = 1'b0;
      @(negedge CLK);
      n_total++;
      if (ERR !== 1'b0) $display("FAIL err_clr: got %b want 0", ERR); else n_pass++;
      {iA, iB} = {iA, iB} ^ 2'b11;
      midx = (midx + 2) % 4;
      for (int k = 1; k <= 20; k++) begin
         @(negedge CLK);
         if (k == 5) ERR_CLR = 1'b1;
         if (k == 6) ERR_CLR = 1'b0;
      end
      n_total++;
      if ({ERR, POS} !== {1'b1, p})
         $display("FAIL err_set_wins: got err=%b pos=%0d want err=1 pos=%0d", ERR, POS, p);
      else n_pass++;
   endtask

   task automatic test_wrap();
      fast_steps(1'b1, 32767);
      n_total++;
      if (f_pos !== 16'h7FFF) $display("FAIL wrap_max: got %h want 7fff", f_pos); else n_pass++;
      n_total++;
      if (f_vel !== 12'h7FF) $display("FAIL vel_saturate: got %h want 7ff", f_vel); else n_pass++;
      fast_steps(1'b1, 1);
      n_total++;
      if (f_pos !== 16'h8000) $display("FAIL wrap_pos: got %h want 8000", f_pos); else n_pass++;
      fzero = 1'b1;
      @(negedge CLK);
      fzero = 1'b0;
      fast_steps(1'b0, 1);
      n_total++;
      if ({f_pos, f_dir, f_err} !== {16'hFFFF, 1'b0, 1'b0})
         $display("FAIL wrap_neg: got pos=%h dir=%b err=%b want pos=ffff dir=0 err=0", f_pos, f_dir, f_err);
      else n_pass++;
   endtask

   task automatic test_velocity();
      int t0, t1, lat;
      bit ok;
      wait_vel_valid(t0, ok);
      n_total++;
      if (ok !== 1'b1) $display("FAIL vel_align_timeout: got none want VEL_VALID"); else n_pass++;
      for (int i = 0; i < 10; i++) main_step(1'b1, 60, 1'b0, lat);
      wait_vel_valid(t1, ok);
      n_total++;
      if ({ok, VEL} !== {1'b1, 12'd10})
         $display("FAIL vel_cw: got valid=%b vel=%0d want valid=1 vel=10", ok, $signed(VEL));
      else n_pass++;
      n_total++;
      if (t1 - t0 !== 1000) $display("FAIL vel_window: got %0d want 1000", t1 - t0); else n_pass++;
      @(negedge CLK);
      n_total++;
      if (VEL_VALID !== 1'b0) $display("FAIL vel_valid_pulse: got %b want 0", VEL_VALID); else n_pass++;
      for (int i = 0; i < 4; i++) main_step(1'b0, 60, 1'b0, lat);
      wait_vel_valid(t0, ok);
      n_total++;
      if ({ok, VEL} !== {1'b1, 12'hFFC})
         $display("FAIL vel_ccw: got valid=%b vel=%0d want valid=1 vel=-4", ok, $signed(VEL));
      else n_pass++;
      repeat (300) @(negedge CLK);
      RST_N = 1'b0;
      #1;
      n_total++;
      if ({POS, DIR, STEP, ERR, VEL, VEL_VALID} !== 32'd0)
         $display("FAIL midreset_outputs: got %h want 0", {POS, DIR, STEP, ERR, VEL, VEL_VALID});
      else n_pass++;
      @(negedge CLK);
      RST_N = 1'b1;
   endtask

   initial begin
      test_reset();
      test_cw_steps();
      test_ccw_zero();
      test_glitch();
      test_illegal();
      test_wrap();
      test_velocity();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
